// File: rtl/face_overlay_ctrl_pkg.sv
// ============================================================================
//  Module      : face_overlay_ctrl_pkg
//  Description : Shared defaults and state encoding for the face-overlay
//                sequencer and the overlay pixel logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package face_overlay_ctrl_pkg;

    // Default geometry shared with the overlay pixel path
    localparam int c_def_cw     = 12;
    localparam int c_def_h_res  = 640;
    localparam int c_def_v_res  = 480;
    localparam int c_def_margin = 10;

    // Collector state: COLLECT accepts beats, PENDING waits for frame start
    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/face_overlay_ctrl_if.sv
// ============================================================================
//  Module      : face_overlay_ctrl_if
//  Description : Detector-to-overlay valid/ready box stream.
//                master : detection engine (drives box beats)
//                slave  : face_overlay_ctrl (drives det_ready)
//  Ports       : det_valid/det_ready handshake, det_x/y/w/h box,
//                det_last end-of-set marker
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface face_overlay_ctrl_if
    import face_overlay_ctrl_pkg::*;
#(
    parameter int CW = c_def_cw
);
    logic          det_valid;
    logic          det_ready;
    logic [CW-1:0] det_x;
    logic [CW-1:0] det_y;
    logic [CW-1:0] det_w;
    logic [CW-1:0] det_h;
    logic          det_last;

    modport master (
        output det_valid, det_x, det_y, det_w, det_h, det_last,
        input  det_ready
    );

    modport slave (
        input  det_valid, det_x, det_y, det_w, det_h, det_last,
        output det_ready
    );
endinterface

`default_nettype wire

// File: rtl/face_overlay_ctrl_box_clamp.sv
// ============================================================================
//  Module      : face_box_clamp
//  Description : Combinational conversion of a (x, y, w, h) face box to
//                margin-expanded corners clamped to the visible area.
//  Ports       : i_x/i_y/i_w/i_h  box top-left and size
//                o_x1/o_y1/o_x2/o_y2  clamped corners
//                o_discard  box is zero-size or starts off-screen
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module face_box_clamp
    import face_overlay_ctrl_pkg::*;
#(
    parameter int CW     = c_def_cw,
    parameter int MARGIN = c_def_margin,
    parameter int H_RES  = c_def_h_res,
    parameter int V_RES  = c_def_v_res
) (
    input  wire logic [CW-1:0] i_x,
    input  wire logic [CW-1:0] i_y,
    input  wire logic [CW-1:0] i_w,
    input  wire logic [CW-1:0] i_h,
    output logic      [CW-1:0] o_x1,
    output logic      [CW-1:0] o_y1,
    output logic      [CW-1:0] o_x2,
    output logic      [CW-1:0] o_y2,
    output logic               o_discard
);
    // Two guard bits: x + w + MARGIN can never wrap
    localparam int EW = CW + 2;

    localparam logic [EW-1:0] c_margin = EW'(MARGIN);
    localparam logic [EW-1:0] c_h_max  = EW'(H_RES - 1);
    localparam logic [EW-1:0] c_v_max  = EW'(V_RES - 1);
    localparam logic [EW-1:0] c_h_res  = EW'(H_RES);
    localparam logic [EW-1:0] c_v_res  = EW'(V_RES);

    logic [EW-1:0] w_x;
    logic [EW-1:0] w_y;
    logic [EW-1:0] w_x_end;
    logic [EW-1:0] w_y_end;

    assign w_x     = EW'(i_x);
    assign w_y     = EW'(i_y);
    assign w_x_end = w_x + EW'(i_w) + c_margin;
    assign w_y_end = w_y + EW'(i_h) + c_margin;

    assign o_x1 = (w_x < c_margin) ? '0 : CW'(w_x - c_margin);
    assign o_y1 = (w_y < c_margin) ? '0 : CW'(w_y - c_margin);
    assign o_x2 = (w_x_end > c_h_max) ? CW'(c_h_max) : CW'(w_x_end);
    assign o_y2 = (w_y_end > c_v_max) ? CW'(c_v_max) : CW'(w_y_end);

    assign o_discard = (i_w == '0) || (i_h == '0) ||
                       (w_x >= c_h_res) || (w_y >= c_v_res);
endmodule

`default_nettype wire

// File: rtl/face_overlay_ctrl.sv
// ============================================================================
//  Module      : face_overlay_ctrl
//  Description : Collects a set of detected face boxes into a shadow bank and
//                commits the whole set to the active overlay bank at the next
//                frame start, so the pixel path never sees a partial set.
//  Ports       : clk, rst_n (async, active-low)
//                i_frame_start   one-cycle top-of-frame pulse
//                det             detector box stream (slave side)
//                o_box_valid     active slot enables
//                o_box_x1/y1/x2/y2  active corners, slot i at [i*CW +: CW]
//                o_commit        pulse when a new set becomes active
//                o_drop_cnt      saturating count of overflowed boxes
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module face_overlay_ctrl
    import face_overlay_ctrl_pkg::*;
#(
    parameter int MAX_FACES   = 4,
    parameter int CW          = c_def_cw,
    parameter int MARGIN      = c_def_margin,
    parameter int H_RES       = c_def_h_res,
    parameter int V_RES       = c_def_v_res,
    parameter int HOLD_FRAMES = 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    i_frame_start,
    face_overlay_ctrl_if.slave           det,
    output logic [MAX_FACES-1:0]         o_box_valid,
    output logic [MAX_FACES*CW-1:0]      o_box_x1,
    output logic [MAX_FACES*CW-1:0]      o_box_y1,
    output logic [MAX_FACES*CW-1:0]      o_box_x2,
    output logic [MAX_FACES*CW-1:0]      o_box_y2,
    output logic                         o_commit,
    output logic [7:0]                   o_drop_cnt
);
    localparam int CNT_W  = $clog2(MAX_FACES + 1);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [CNT_W-1:0]  c_max_cnt   = CNT_W'(MAX_FACES);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_FRAMES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_run;        // low until the first edge after reset
    logic [CNT_W-1:0]    r_count;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [7:0]          r_drop_cnt;
    logic                r_commit;
    logic [MAX_FACES-1:0] r_box_valid;

    logic [CW-1:0] r_sh_x1 [MAX_FACES];
    logic [CW-1:0] r_sh_y1 [MAX_FACES];
    logic [CW-1:0] r_sh_x2 [MAX_FACES];
    logic [CW-1:0] r_sh_y2 [MAX_FACES];
    logic [CW-1:0] r_ac_x1 [MAX_FACES];
    logic [CW-1:0] r_ac_y1 [MAX_FACES];
    logic [CW-1:0] r_ac_x2 [MAX_FACES];
    logic [CW-1:0] r_ac_y2 [MAX_FACES];

    logic [CW-1:0]        w_x1;
    logic [CW-1:0]        w_y1;
    logic [CW-1:0]        w_x2;
    logic [CW-1:0]        w_y2;
    logic                 w_discard;
    logic                 w_accept;
    logic                 w_full;
    logic                 w_wr;
    logic                 w_drop;
    logic                 w_commit;
    logic [MAX_FACES-1:0] w_mask;

    face_box_clamp #(
        .CW     (CW),
        .MARGIN (MARGIN),
        .H_RES  (H_RES),
        .V_RES  (V_RES)
    ) u_clamp (
        .i_x       (det.det_x),
        .i_y       (det.det_y),
        .i_w       (det.det_w),
        .i_h       (det.det_h),
        .o_x1      (w_x1),
        .o_y1      (w_y1),
        .o_x2      (w_x2),
        .o_y2      (w_y2),
        .o_discard (w_discard)
    );

    // Ready is combinational from state so it is low the instant reset asserts
    assign det.det_ready = r_run && (r_state == ST_COLLECT);

    assign w_accept = det.det_valid && det.det_ready;
    assign w_full   = (r_count == c_max_cnt);
    assign w_wr     = w_accept && !w_discard && !w_full;
    assign w_drop   = w_accept && !w_discard && w_full;
    assign w_commit = (r_state == ST_PENDING) && i_frame_start;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    // A det_last accepted together with frame_start lands in PENDING only
    // after this frame_start has passed, so that set waits a full frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COLLECT: if (w_accept && det.det_last) w_state_nxt = ST_PENDING;
            ST_PENDING: if (i_frame_start)            w_state_nxt = ST_COLLECT;
            default:                                  w_state_nxt = ST_COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow count, drop counter, hold timer, active enables
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_drop_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_commit    <= 1'b0;
            r_box_valid <= '0;
        end else begin
            r_commit <= w_commit;

            if (w_commit) begin
                r_count <= '0;
            end else if (w_wr) begin
                r_count <= r_count + 1'b1;
            end

            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end

            if (w_commit) begin
                r_box_valid <= w_mask;
                r_hold_cnt  <= '0;
            end else if (i_frame_start) begin
                // Stale set expires after HOLD_FRAMES frames without a commit
                if (r_hold_cnt == c_hold_last) begin
                    r_box_valid <= '0;
                end else begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-slot shadow and active banks
    // ------------------------------------------------------------------
    for (genvar i = 0; i < MAX_FACES; i++) begin : g_slot
        localparam logic [CNT_W-1:0] c_idx = CNT_W'(i);

        assign w_mask[i] = (c_idx < r_count);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sh_x1[i] <= '0;
                r_sh_y1[i] <= '0;
                r_sh_x2[i] <= '0;
                r_sh_y2[i] <= '0;
            end else if (w_wr && (r_count == c_idx)) begin
                r_sh_x1[i] <= w_x1;
                r_sh_y1[i] <= w_y1;
                r_sh_x2[i] <= w_x2;
                r_sh_y2[i] <= w_y2;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ac_x1[i] <= '0;
                r_ac_y1[i] <= '0;
                r_ac_x2[i] <= '0;
                r_ac_y2[i] <= '0;
            end else if (w_commit) begin
                r_ac_x1[i] <= r_sh_x1[i];
                r_ac_y1[i] <= r_sh_y1[i];
                r_ac_x2[i] <= r_sh_x2[i];
                r_ac_y2[i] <= r_sh_y2[i];
            end
        end

        assign o_box_x1[i*CW +: CW] = r_ac_x1[i];
        assign o_box_y1[i*CW +: CW] = r_ac_y1[i];
        assign o_box_x2[i*CW +: CW] = r_ac_x2[i];
        assign o_box_y2[i*CW +: CW] = r_ac_y2[i];
    end

    assign o_box_valid = r_box_valid;
    assign o_commit    = r_commit;
    assign o_drop_cnt  = r_drop_cnt;
endmodule

`default_nettype wire
